// File: rtl/systolic_array_controller_if.sv
// systolic_array_controller_if: job request and array-edge handshake bundle for the controller
interface systolic_array_controller_if #(
    parameter int K_WIDTH = 16
);
    logic               start_i;
    logic [K_WIDTH-1:0] k_len_i;
    logic               beat_ack_i;
    logic               last_ack_i;
    logic               drain_ack_i;
    logic               inputs_valid_o;
    logic               last_element_o;
    logic [K_WIDTH-1:0] rd_addr_o;
    logic               drain_mode_o;
    logic               select_accumulator_o;
    logic               busy_o;
    logic               done_o;
    logic               error_o;
    modport master (
        input  start_i, k_len_i, beat_ack_i, last_ack_i, drain_ack_i,
        output inputs_valid_o, last_element_o, rd_addr_o, drain_mode_o,
               select_accumulator_o, busy_o, done_o, error_o
    );
    modport slave (
        output start_i, k_len_i, beat_ack_i, last_ack_i, drain_ack_i,
        input  inputs_valid_o, last_element_o, rd_addr_o, drain_mode_o,
               select_accumulator_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/systolic_array_controller.sv
// systolic_array_controller: sequences K compute beats, waits for the far-corner last pulse,
// then drains COLS accumulator beats. Optional watchdog enabled by defining CTRL_TIMEOUT_EN.
module systolic_array_controller #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int K_WIDTH       = 16,
    parameter int TIMEOUT_WIDTH = 16
) (
    input logic clk_i,
    input logic rstn_i,
    systolic_array_controller_if.master bus
);
    typedef enum logic [2:0] {IDLE, FEED, WAIT_ACK, WAIT_LAST, DRAIN_ISSUE, DRAIN_WAIT, DONE} state_t;
    state_t             state;
    logic [K_WIDTH-1:0] k_len;
    logic [K_WIDTH-1:0] beat;
    logic [K_WIDTH-1:0] drain;
    logic               last_seen;
    logic               final_beat;
    logic               drain_mode;
    assign final_beat = beat == k_len - K_WIDTH'(1);
    assign drain_mode = state == DRAIN_ISSUE || state == DRAIN_WAIT;
`ifdef CTRL_TIMEOUT_EN
    state_t                   prev;
    logic [TIMEOUT_WIDTH-1:0] wd;
    logic                     err;
    logic                     waiting;
    logic                     expired;
    assign waiting = state == WAIT_ACK || state == WAIT_LAST || state == DRAIN_WAIT;
    assign expired = waiting && &wd;
    // Watchdog: restarts on every state change, counts only while waiting on an ack
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prev <= IDLE;
            wd   <= '0;
            err  <= 1'b0;
        end else begin
            prev <= state;
            wd   <= (waiting && state == prev) ? wd + 1'b1 : '0;
            err  <= expired ? 1'b1 : (state == IDLE && bus.start_i) ? 1'b0 : err;
        end
    end
`endif
    // Job sequencer: compute beats, last-element wait, accumulator drain
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            k_len     <= '0;
            beat      <= '0;
            drain     <= '0;
            last_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start_i) begin
                    k_len     <= bus.k_len_i;
                    beat      <= '0;
                    last_seen <= 1'b0;
                    state     <= (bus.k_len_i == '0) ? DONE : FEED;
                end
                FEED: state <= WAIT_ACK;
                WAIT_ACK: begin
                    // the corner pulse may beat the final edge ack; remember it
                    if (final_beat && bus.last_ack_i) last_seen <= 1'b1;
                    if (bus.beat_ack_i) begin
                        if (!final_beat) begin
                            beat  <= beat + 1'b1;
                            state <= FEED;
                        end else if (last_seen || bus.last_ack_i) begin
                            drain <= '0;
                            state <= DRAIN_ISSUE;
                        end else begin
                            state <= WAIT_LAST;
                        end
                    end
                end
                WAIT_LAST: if (bus.last_ack_i) begin
                    drain <= '0;
                    state <= DRAIN_ISSUE;
                end
                DRAIN_ISSUE: state <= DRAIN_WAIT;
                DRAIN_WAIT: if (bus.drain_ack_i) begin
                    drain <= drain + 1'b1;
                    state <= (drain == K_WIDTH'(COLS - 1)) ? DONE : DRAIN_ISSUE;
                end
                default: state <= IDLE;
            endcase
`ifdef CTRL_TIMEOUT_EN
            if (expired) state <= DONE;
`endif
        end
    end
    // Moore output decode from registered state and counters
    always_comb begin
        bus.inputs_valid_o       = state == FEED || state == DRAIN_ISSUE;
        bus.last_element_o       = state == FEED && final_beat;
        bus.rd_addr_o            = state == FEED ? beat : state == DRAIN_ISSUE ? drain : '0;
        bus.drain_mode_o         = drain_mode;
        bus.select_accumulator_o = drain_mode;
        bus.busy_o               = state != IDLE;
        bus.done_o               = state == DONE;
`ifdef CTRL_TIMEOUT_EN
        bus.error_o              = err;
`else
        bus.error_o              = 1'b0;
`endif
    end
endmodule

// File: tb/tb_systolic_array_controller.sv
// tb_systolic_array_controller: randomized and directed jobs checked against a transaction-level model
`timescale 1ns/1ps
module tb_systolic_array_controller;
    localparam int KW     = 4;
    localparam int COLS   = 4;
    localparam int BUDGET = 400;
`ifdef CTRL_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 16;
`endif
    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    int total   = 0;
    int bad     = 0;
    int dones   = 0;
    int sel_err = 0;
    logic [KW+1:0] seen[$];

    systolic_array_controller_if #(.K_WIDTH(KW)) bus ();
    systolic_array_controller #(.ROWS(4), .COLS(COLS), .K_WIDTH(KW), .TIMEOUT_WIDTH(TW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    // Record every strobe as {drain_mode, last_element, rd_addr} and count done pulses
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (bus.inputs_valid_o) seen.push_back({bus.drain_mode_o, bus.last_element_o, bus.rd_addr_o});
            if (bus.done_o) dones++;
            if (bus.select_accumulator_o !== bus.drain_mode_o) sel_err++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_i);
    endtask

    // Expected job: n compute beats addr 0..n-1 (last on n-1), then COLS drain beats addr 0..COLS-1
    task automatic compare(input string tag, input int n);
        int exp_len;
        logic [KW+1:0] e;
        exp_len = (n == 0) ? 0 : n + COLS;
        check({tag, "_len"}, 32'(seen.size()), 32'(exp_len));
        for (int i = 0; i < seen.size() && i < exp_len; i++) begin
            e = (i < n) ? {1'b0, i == n - 1, KW'(i)} : {1'b1, 1'b0, KW'(i - n)};
            check({tag, "_strobe"}, 32'(seen[i]), 32'(e));
        end
        check({tag, "_done_cnt"}, 32'(dones), 32'd1);
        seen.delete();
        dones = 0;
    endtask

    // lm: 0 last_ack with final beat ack, 1 last_ack ld cycles after it, 2 last_ack one cycle before it
    task automatic run_job(input int n, input int bd, input int ld, input int dd, input int lm, input bit mid);
        int cyc = 0;
        int beats = 0;
        int bc = 0;
        int lc = 0;
        int dc = 0;
        int fa = -1;
        int fd = -1;
        bit fin = 0;
        bit mid_done = 0;
        bus.start_i = 1'b1;
        bus.k_len_i = KW'(n);
        @(negedge clk_i);
        bus.start_i = 1'b0;
        while (!fin && cyc < BUDGET) begin
            bus.beat_ack_i  = 1'b0;
            bus.last_ack_i  = 1'b0;
            bus.drain_ack_i = 1'b0;
            bus.start_i     = 1'b0;
            if (bus.done_o) fin = 1;
            if (bus.inputs_valid_o && bus.drain_mode_o && fd < 0) fd = cyc;
            if (lc > 0) begin
                lc--;
                if (lc == 0) bus.last_ack_i = 1'b1;
            end
            if (dc > 0) begin
                dc--;
                if (dc == 0) bus.drain_ack_i = 1'b1;
            end
            if (bc > 0) begin
                bc--;
                if (bc == 0) begin
                    bus.beat_ack_i = 1'b1;
                    if (beats == n) begin
                        fa = cyc;
                        if (lm == 0) bus.last_ack_i = 1'b1;
                        else if (lm == 1) lc = ld;
                    end
                end
            end
            if (bus.inputs_valid_o && !bus.drain_mode_o) begin
                beats++;
                bc = bd;
                if (lm == 2 && beats == n) lc = bd - 1;
            end
            if (bus.inputs_valid_o && bus.drain_mode_o) dc = dd;
            if (mid && !mid_done && beats == 2) begin
                bus.start_i = 1'b1;
                bus.k_len_i = KW'(7);
                mid_done = 1;
            end
            @(negedge clk_i);
            cyc++;
        end
        bus.start_i = 1'b0;
        check("job_done_seen", 32'(fin), 32'd1);
        if (n == 0) check("zero_done_latency", 32'(cyc <= 1), 32'd1);
        if (n > 0 && lm == 0) check("same_cycle_drain_start", 32'(fd - fa), 32'd1);
        check("idle_after_done", 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        int n, bd, ld, dd, lm;
        bus.start_i = 1'b0;
        bus.k_len_i = '0;
        bus.beat_ack_i = 1'b0;
        bus.last_ack_i = 1'b0;
        bus.drain_ack_i = 1'b0;
        // reset held for 3 cycles, outputs all zero
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("reset_outputs", 32'({bus.inputs_valid_o, bus.last_element_o, bus.rd_addr_o, bus.drain_mode_o,
                   bus.select_accumulator_o, bus.busy_o, bus.done_o, bus.error_o}), 32'd0);
        end
        rstn_i = 1'b1;
        @(negedge clk_i);
        check("busy_after_release", 32'(bus.busy_o), 32'd0);
        // directed: k_len=4, acks at 3 / 5 / 2 cycles
        run_job(4, 3, 5, 2, 1, 0);
        cycles(3);
        compare("k4", 4);
        // k_len=0: straight to done
        run_job(0, 1, 1, 1, 1, 0);
        cycles(3);
        compare("k0", 0);
        // start pulsed mid-job is ignored
        run_job(3, 2, 2, 1, 1, 1);
        cycles(10);
        compare("midstart", 3);
        // last_ack together with the final beat ack
        run_job(2, 2, 1, 1, 0, 0);
        cycles(3);
        compare("same_cycle", 2);
        // last_ack one cycle ahead of the final beat ack is captured
        run_job(3, 3, 1, 2, 2, 0);
        cycles(3);
        compare("early_last", 3);
        // maximum job length for the bench width
        run_job(15, 1, 1, 1, 1, 0);
        cycles(3);
        compare("kmax", 15);
        // randomized jobs
        for (int j = 0; j < 6; j++) begin
            n  = $urandom_range(1, 6);
            bd = $urandom_range(2, 4);
            ld = $urandom_range(1, 5);
            dd = $urandom_range(1, 3);
            lm = $urandom_range(0, 2);
            run_job(n, bd, ld, dd, lm, 0);
            cycles(3);
            compare("random", n);
        end
`ifdef CTRL_TIMEOUT_EN
        begin
            int cyc = 0;
            bit fin = 0;
            bus.start_i = 1'b1;
            bus.k_len_i = KW'(2);
            @(negedge clk_i);
            bus.start_i = 1'b0;
            while (!fin && cyc < 60) begin
                if (bus.done_o) fin = 1;
                else begin
                    @(negedge clk_i);
                    cyc++;
                end
            end
            check("timeout_done", 32'(fin), 32'd1);
            check("timeout_window", 32'(cyc >= 12 && cyc <= 22), 32'd1);
            @(negedge clk_i);
            check("timeout_error_set", 32'(bus.error_o), 32'd1);
            check("timeout_idle", 32'(bus.busy_o), 32'd0);
            bus.start_i = 1'b1;
            bus.k_len_i = '0;
            @(negedge clk_i);
            bus.start_i = 1'b0;
            check("timeout_error_cleared", 32'(bus.error_o), 32'd0);
            cycles(3);
            seen.delete();
            dones = 0;
        end
`endif
        // reset asserted mid-job returns outputs to zero at once
        bus.start_i = 1'b1;
        bus.k_len_i = KW'(3);
        @(negedge clk_i);
        bus.start_i = 1'b0;
        check("midjob_busy", 32'(bus.busy_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        check("midjob_reset_outputs", 32'({bus.inputs_valid_o, bus.rd_addr_o, bus.drain_mode_o,
               bus.busy_o, bus.done_o, bus.error_o}), 32'd0);
        cycles(2);
        rstn_i = 1'b1;
        @(negedge clk_i);
        check("busy_after_midjob_reset", 32'(bus.busy_o), 32'd0);
        check("select_acc_tracks_drain", 32'(sel_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
